frame_unpacker: RTL and testbench
=================================

FRAME_UNPACKER -- requirements
Module: frame_unpacker

Interface
REQ-001 Parameter HEADER, bit [11:0], default 12'h345: expected header field value.
REQ-002 Parameter TRAILER, bit [15:0], default 16'h3456: expected trailer field value.
REQ-003 Parameter TIMEOUT, int, default 16: maximum idle cycles between bytes of one frame; 0 disables the timeout.
REQ-004 i_clk  input  1: sole clock; all state changes on its rising edge.
REQ-005 i_rst  input  1: reset, synchronous, active-high.
REQ-006 i_data  input  8: byte stream in, MSB-first.
REQ-007 i_valid  input  1: i_data valid.
REQ-008 o_ready  output  1: unpacker can accept a byte.
REQ-009 o_abc  output  1: frame bit 31.
REQ-010 o_def  output  3: frame bits 18:16.
REQ-011 o_hdr_err  output  1: frame bits 30:19 differ from HEADER.
REQ-012 o_trl_err  output  1: frame bits 15:0 differ from TRAILER.
REQ-013 o_valid  output  1: output fields valid.
REQ-014 i_ready  input  1: downstream accepts the output.
REQ-015 o_timeout  output  1: one-cycle pulse on a mid-frame abort.
REQ-016 o_err_count  output  8: saturating count of frames with any error.

Function
REQ-017 A frame is 4 bytes: byte0 = bits 31:24, byte1 = 23:16, byte2 = 15:8, byte3 = 7:0.
REQ-018 A byte is accepted only in a cycle where i_valid and o_ready are both high.
REQ-019 States: S_B0, S_B1, S_B2, S_B3, S_OUT.
REQ-020 Each accepted byte advances the FSM one state, S_B0 through S_B3.
REQ-021 A byte accepted in S_B3 moves the FSM to S_OUT.
REQ-022 o_ready = 1 in S_B0..S_B3 and 0 in S_OUT.
REQ-023 In S_OUT, o_valid = 1 and o_abc, o_def, o_hdr_err and o_trl_err are registered and held stable until i_ready = 1.
REQ-024 Latency: byte3 accepted at edge N; o_valid is high from edge N+1.
REQ-025 In S_OUT with i_ready = 1: the output completes, and the FSM returns to S_B0 at the next edge.
REQ-026 No byte is accepted in the S_OUT cycle; back-to-back frames therefore cost 5 cycles minimum.
REQ-027 o_valid, once high, never drops without i_ready.
REQ-028 Header and trailer checks are exact compares of the full-width fields.
REQ-029 Both error flags may be set in the same frame.
REQ-030 o_err_count increments by 1 when an output completes with (o_hdr_err | o_trl_err); it saturates at 8'hFF.
REQ-031 When TIMEOUT > 0, an idle counter clears on every accepted byte and in S_B0 and S_OUT.
REQ-032 The idle counter increments in each S_B1..S_B3 cycle with no accepted byte.
REQ-033 When the idle counter reaches TIMEOUT, the FSM returns to S_B0 and discards partial data.
REQ-034 That timeout event pulses o_timeout for exactly 1 cycle and leaves o_err_count unchanged.
REQ-035 If a byte is accepted in the same cycle the idle counter would reach TIMEOUT, the byte wins and no timeout occurs.
REQ-036 Partial data registers are don't-care outside S_OUT; outputs are driven only from the held frame register.

Reset
REQ-037 While i_rst = 1 at an edge: FSM enters S_B0; o_valid = 0, o_timeout = 0, o_err_count = 0, idle counter = 0; o_abc, o_def, o_hdr_err and o_trl_err = 0.
REQ-038 Reset mid-frame or in S_OUT discards the frame with no output or count update.
REQ-039 o_ready = 1 in the first cycle after reset deasserts.

Structure
REQ-040 Shared package frame_pkg SHALL hold the state enum, FRAME_W = 32, BYTE_W = 8, and field offsets/widths (ABC_POS = 31, HDR_MSB/LSB = 30/19, DEF_MSB/LSB = 18/16, TRL_MSB/LSB = 15/0).
REQ-041 The 8-bit saturating counter SHALL be a sub-module sat_counter (WIDTH parameter, inputs clear and increment, output count), reused by the matching frame packer.

Verification
REQ-042 Bytes 8'hB4,8'h5D,8'h34,8'h56 with i_ready = 1 -> frame 32'hB45D3456 -> o_abc = 1, o_def = 3'b101, no error flags; o_valid 1 cycle after byte3.
REQ-043 Bytes 8'h00,8'h00,8'h34,8'h56 -> o_hdr_err = 1, o_trl_err = 0, o_err_count = 1 after handshake.
REQ-044 Valid frame, i_ready held 0 for 10 cycles -> o_valid and fields stable and o_ready = 0 throughout; completes on the first i_ready = 1 cycle.
REQ-045 TIMEOUT = 4; send 2 bytes then idle -> o_timeout pulses once; FSM in S_B0; next 4 bytes 8'h34,8'h5A,8'h34,8'h56 decode cleanly.
REQ-046 Send 256 frames with a bad trailer -> o_err_count = 8'hFF and holds.
REQ-047 i_rst asserted after byte2 -> no o_valid; following frame 8'h34,8'h5B,8'h34,8'h56 -> o_abc = 0, o_def = 3'b011, no error flags.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared frame layout, FSM state encoding and field decode for the frame unpacker/packer pair.
package frame_pkg;

  localparam int unsigned FRAME_W = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned PART_W  = FRAME_W - BYTE_W;

  localparam int unsigned ABC_POS = 31;
  localparam int unsigned HDR_MSB = 30;
  localparam int unsigned HDR_LSB = 19;
  localparam int unsigned DEF_MSB = 18;
  localparam int unsigned DEF_LSB = 16;
  localparam int unsigned TRL_MSB = 15;
  localparam int unsigned TRL_LSB = 0;

  localparam int unsigned HDR_W = HDR_MSB - HDR_LSB + 1;
  localparam int unsigned DEF_W = DEF_MSB - DEF_LSB + 1;
  localparam int unsigned TRL_W = TRL_MSB - TRL_LSB + 1;

  typedef enum logic [2:0] {
    S_B0  = 3'd0,
    S_B1  = 3'd1,
    S_B2  = 3'd2,
    S_B3  = 3'd3,
    S_OUT = 3'd4
  } state_e;

  typedef struct packed {
    logic             abc;
    logic [DEF_W-1:0] def;
    logic             hdr_err;
    logic             trl_err;
  } fields_t;

  // Split a complete frame into its output fields and check header/trailer.
  function automatic fields_t decode_frame(input logic [FRAME_W-1:0] frame,
                                           input logic [HDR_W-1:0]   hdr,
                                           input logic [TRL_W-1:0]   trl);
    fields_t f;
    f.abc     = frame[ABC_POS];
    f.def     = frame[DEF_MSB:DEF_LSB];
    f.hdr_err = (frame[HDR_MSB:HDR_LSB] != hdr);
    f.trl_err = (frame[TRL_MSB:TRL_LSB] != trl);
    return f;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; shared by frame packer and unpacker.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_increment,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      count_q <= '0;
    end else if (i_increment && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/frame_unpacker.sv
// Collects four MSB-first bytes into a frame, presents decoded fields with a
// valid/ready handshake, and aborts partial frames after an idle timeout.
module frame_unpacker
  import frame_pkg::*;
#(
  parameter bit [11:0] HEADER  = 12'h345,
  parameter bit [15:0] TRAILER = 16'h3456,
  parameter int        TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_abc,
  output logic [2:0]  o_def,
  output logic        o_hdr_err,
  output logic        o_trl_err,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_timeout,
  output logic [7:0]  o_err_count
);

  localparam int unsigned IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e              state_q;
  logic [PART_W-1:0]   data_q;
  fields_t             fields_q;
  logic                valid_q;
  logic                ready_q;
  logic                timeout_q;
  logic [IDLE_W-1:0]   idle_q;

  logic                accept;
  logic                done;
  logic                err_done;
  logic                in_frame;
  logic                tmo_hit;
  logic [FRAME_W-1:0]  frame_c;

  assign accept   = i_valid & ready_q;
  assign done     = valid_q & i_ready;
  assign err_done = done & (fields_q.hdr_err | fields_q.trl_err);
  assign in_frame = (state_q == S_B1) || (state_q == S_B2) || (state_q == S_B3);
  assign frame_c  = {data_q, i_data};

  // An accepted byte always beats the timeout that would fire on the same edge.
  assign tmo_hit  = (TIMEOUT > 0) && in_frame && !accept &&
                    (idle_q == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_B0;
      data_q    <= '0;
      fields_q  <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      timeout_q <= 1'b0;
      idle_q    <= '0;
    end else begin
      timeout_q <= 1'b0;

      case (state_q)
        S_B0: begin
          if (accept) begin
            data_q  <= {data_q[PART_W-BYTE_W-1:0], i_data};
            state_q <= S_B1;
          end
        end
        S_B1: begin
          if (accept) begin
            data_q  <= {data_q[PART_W-BYTE_W-1:0], i_data};
            state_q <= S_B2;
          end
        end
        S_B2: begin
          if (accept) begin
            data_q  <= {data_q[PART_W-BYTE_W-1:0], i_data};
            state_q <= S_B3;
          end
        end
        S_B3: begin
          if (accept) begin
            fields_q <= decode_frame(frame_c, HEADER, TRAILER);
            valid_q  <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= S_OUT;
          end
        end
        S_OUT: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_B0;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_B0;
        end
      endcase

      // Idle tracking only runs between bytes of a partially received frame.
      if (!in_frame || accept) begin
        idle_q <= '0;
      end else if (tmo_hit) begin
        idle_q    <= '0;
        timeout_q <= 1'b1;
        state_q   <= S_B0;
      end else if (TIMEOUT > 0) begin
        idle_q <= idle_q + IDLE_W'(1);
      end
    end
  end

  sat_counter #(
    .WIDTH (8)
  ) u_err_cnt (
    .i_clk       (i_clk),
    .i_clear     (i_rst),
    .i_increment (err_done),
    .o_count     (o_err_count)
  );

  assign o_ready   = ready_q;
  assign o_valid   = valid_q;
  assign o_timeout = timeout_q;
  assign o_abc     = fields_q.abc;
  assign o_def     = fields_q.def;
  assign o_hdr_err = fields_q.hdr_err;
  assign o_trl_err = fields_q.trl_err;

endmodule

// File: tb/tb_frame_unpacker.sv
// Scoreboard bench for frame_unpacker: frames are modelled on send, checked on handshake.
module tb_frame_unpacker;

  // The example vectors carry the 0x345 pattern one bit high, i.e. 12'h68B in bits 30:19.
  localparam logic [11:0] HDR = 12'h68B;
  localparam logic [15:0] TRL = 16'h3456;
  localparam int          TMO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready_in;
  logic       o_ready, o_abc, o_hdr_err, o_trl_err, o_valid, o_timeout;
  logic [2:0] o_def;
  logic [7:0] o_err_count;

  always #5 clk = ~clk;

  frame_unpacker #(
    .HEADER  (HDR),
    .TRAILER (TRL),
    .TIMEOUT (TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_data      (data),
    .i_valid     (valid),
    .o_ready     (o_ready),
    .o_abc       (o_abc),
    .o_def       (o_def),
    .o_hdr_err   (o_hdr_err),
    .o_trl_err   (o_trl_err),
    .o_valid     (o_valid),
    .i_ready     (ready_in),
    .o_timeout   (o_timeout),
    .o_err_count (o_err_count)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic       abc;
    logic [2:0] def;
    logic       hdr;
    logic       trl;
  } exp_t;

  exp_t sb[$];
  int   exp_cnt = 0;
  int   n_tmo   = 0;
  int   n_out   = 0;
  logic       hold_v = 1'b0;
  logic [5:0] hold_f;

  function automatic exp_t model(input logic [31:0] f);
    exp_t e;
    e.abc = f[31];
    e.def = f[18:16];
    e.hdr = (f[30:19] != HDR);
    e.trl = (f[15:0] != TRL);
    return e;
  endfunction

  // Output monitor: stability while stalled, scoreboard compare on handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 0;
      hold_v  = 1'b0;
    end else begin
      if (o_timeout) n_tmo++;
      if (hold_v) check("valid_held", 32'(o_valid), 32'd1);
      if (o_valid) begin
        check("ready_in_out", 32'(o_ready), 32'd0);
        if (hold_v) check("fields_held", 32'({o_abc, o_def, o_hdr_err, o_trl_err}), 32'(hold_f));
        if (ready_in) begin
          hold_v = 1'b0;
          if (sb.size() == 0) begin
            check("spurious_out", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("abc", 32'(o_abc), 32'(e.abc));
            check("def", 32'(o_def), 32'(e.def));
            check("hdr_err", 32'(o_hdr_err), 32'(e.hdr));
            check("trl_err", 32'(o_trl_err), 32'(e.trl));
            check("err_count", 32'(o_err_count), 32'(exp_cnt));
            if ((e.hdr || e.trl) && exp_cnt < 255) exp_cnt++;
            n_out++;
          end
        end else begin
          hold_v = 1'b1;
          hold_f = {o_abc, o_def, o_hdr_err, o_trl_err};
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok    = 1'b0;
    valid = 1'b1;
    data  = b;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_wait", 32'(ok), 32'd1);
    tick();
    valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] f, input int gap);
    for (int k = 3; k >= 0; k--) begin
      send_byte(f[k*8 +: 8]);
      if (k > 0) repeat (gap) tick();
    end
    sb.push_back(model(f));
    check("latency", 32'(o_valid), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int t0;
    int o0;
    logic [7:0] c0;

    rst = 1'b1; valid = 1'b0; data = '0; ready_in = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    check("rst_cnt", 32'(o_err_count), 32'd0);
    check("rst_fields", 32'({o_abc, o_def, o_hdr_err, o_trl_err}), 32'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(o_ready), 32'd1);

    // Clean frame with explicit field values.
    send_frame(32'hB45D3456, 0);
    check("t1_abc", 32'(o_abc), 32'd1);
    check("t1_def", 32'(o_def), 32'd5);
    check("t1_errs", 32'({o_hdr_err, o_trl_err}), 32'd0);
    drain();

    // Bad header only.
    send_frame(32'h00003456, 0);
    check("t2_hdr", 32'(o_hdr_err), 32'd1);
    check("t2_trl", 32'(o_trl_err), 32'd0);
    drain();
    check("t2_cnt", 32'(o_err_count), 32'd1);

    // Both flags in one frame.
    send_frame(32'h12340000, 0);
    drain();
    check("t2b_cnt", 32'(o_err_count), 32'd2);

    // Downstream stall for 10 cycles.
    ready_in = 1'b0;
    send_frame(32'hB45E3456, 0);
    repeat (10) begin
      tick();
      check("stall_ready", 32'(o_ready), 32'd0);
      check("stall_valid", 32'(o_valid), 32'd1);
    end
    ready_in = 1'b1;
    tick();
    check("stall_done", 32'(o_valid), 32'd0);
    check("stall_ready_back", 32'(o_ready), 32'd1);
    drain();

    // Mid-frame timeout, then a clean frame.
    t0 = n_tmo;
    c0 = o_err_count;
    send_byte(8'h34);
    send_byte(8'h5A);
    repeat (10) tick();
    check("tmo_pulses", 32'(n_tmo - t0), 32'd1);
    check("tmo_cnt", 32'(o_err_count), 32'(c0));
    check("tmo_ready", 32'(o_ready), 32'd1);
    check("tmo_no_out", 32'(o_valid), 32'd0);
    send_frame(32'h345A3456, 0);
    check("t4_abc", 32'(o_abc), 32'd0);
    check("t4_def", 32'(o_def), 32'd2);
    check("t4_errs", 32'({o_hdr_err, o_trl_err}), 32'd0);
    drain();

    // Gaps of TIMEOUT-1 idle cycles: each byte lands on the would-be timeout edge.
    t0 = n_tmo;
    send_frame(32'hB45F3456, TMO - 1);
    check("gap_no_tmo", 32'(n_tmo - t0), 32'd0);
    drain();

    // Reset after byte2 discards the frame.
    o0 = n_out;
    send_byte(8'h34);
    send_byte(8'h5B);
    send_byte(8'h34);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rst_mid_valid", 32'(o_valid), 32'd0);
    check("rst_mid_cnt", 32'(o_err_count), 32'd0);
    check("rst_mid_no_out", 32'(n_out - o0), 32'd0);
    send_frame(32'h345B3456, 0);
    check("t5_abc", 32'(o_abc), 32'd0);
    check("t5_def", 32'(o_def), 32'd3);
    check("t5_errs", 32'({o_hdr_err, o_trl_err}), 32'd0);
    drain();

    // 256 bad-trailer frames saturate the error counter.
    for (int n = 0; n < 256; n++) send_frame(32'h345B0000, 0);
    drain();
    check("sat_ff", 32'(o_err_count), 32'hFF);
    send_frame(32'h345B0001, 0);
    drain();
    check("sat_hold", 32'(o_err_count), 32'hFF);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
